vga_fb_arbiter: RTL and testbench

- Schedules a single-port 8-bit framebuffer SRAM shared by the vga scanout and a drawing client.
- Issues display reads on a fixed per-pixel-group schedule, derived from the vga hcounter/vcounter, and presents an 8-bit pixels word that is aligned to the pixel group being scanned.
- Grants client writes in all remaining cycles.
- Contains a clear-screen engine that zero-fills the framebuffer using write slots.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_fetch_sched.sv | 86 ++++++++
 rtl/vga_fb_arbiter.sv | 115 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg: shared VGA timing and framebuffer constants, clear states |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vga_pkg;

    localparam int H_VISIBLE      = 640;
    localparam int H_TOTAL        = 800;
    localparam int V_VISIBLE      = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 80;
    localparam int FB_WORDS       = V_VISIBLE * WORDS_PER_LINE;

    // Last in-line fetch is for group 79; the next line's group 0 comes from hblank.
    localparam int SLOT_A_LAST_H  = H_VISIBLE - 16;
    localparam int SLOT_B_H       = H_TOTAL - 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_fetch_sched: display read-slot decode, read address counter,   |
// | SRAM data staging and pixel-group output register                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_fetch_sched
    import vga_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcounter,
    input  logic [9:0]        vcounter,
    input  logic [7:0]        sram_rdata,
    output logic              rd_slot,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        pixels
);

    localparam logic [10:0] C_SLOT_A_LAST = 11'(SLOT_A_LAST_H);
    localparam logic [10:0] C_SLOT_B_H    = 11'(SLOT_B_H);
    localparam logic [9:0]  C_V_VISIBLE   = 10'(V_VISIBLE);
    localparam logic [9:0]  C_V_LAST_VIS  = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  C_V_LAST      = 10'(V_TOTAL - 1);

    logic              w_slot_a;
    logic              w_slot_b;
    logic              w_frame_start;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              re_dly_q, re_dly_d;
    logic [7:0]        stage_q, stage_d;
    logic [7:0]        pixels_q, pixels_d;
    logic              synced_q, synced_d;

    assign w_slot_a      = (vcounter < C_V_VISIBLE) && (hcounter[2:0] == 3'd0)
                           && (hcounter <= C_SLOT_A_LAST);
    assign w_slot_b      = (hcounter == C_SLOT_B_H)
                           && ((vcounter < C_V_LAST_VIS) || (vcounter == C_V_LAST));
    assign w_frame_start = w_slot_b && (vcounter == C_V_LAST);

    assign rd_slot = w_slot_a || w_slot_b;
    assign rd_addr = w_frame_start ? '0 : rd_addr_q;
    assign pixels  = pixels_q;

    always_comb begin
        rd_addr_d = rd_addr_q;
        re_dly_d  = rd_slot;
        stage_d   = stage_q;
        pixels_d  = pixels_q;
        synced_d  = synced_q;
        if (w_frame_start) begin
            rd_addr_d = ADDR_W'(1);
            synced_d  = 1'b1;
        end else if (rd_slot) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (re_dly_q) begin
            stage_d = sram_rdata;
        end
        // Until a frame-start fetch realigns the address, staged data is not trustworthy.
        if ((hcounter[2:0] == 3'd7) && synced_q) begin
            pixels_d = stage_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q <= '0;
            re_dly_q  <= 1'b0;
            stage_q   <= '0;
            pixels_q  <= '0;
            synced_q  <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            re_dly_q  <= re_dly_d;
            stage_q   <= stage_d;
            pixels_q  <= pixels_d;
            synced_q  <= synced_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_fb_arbiter: single-port framebuffer scheduler (display reads,  |
// | clear-screen engine, client writes)                                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W            = 16,
    parameter int BLANK_WRITES_ONLY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcounter,
    input  logic [9:0]        vcounter,
    output logic [7:0]        pixels,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [7:0]        sram_rdata
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [9:0]        C_V_LAST_VIS = 10'(V_VISIBLE - 1);

    logic              w_rd_slot;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_eligible;
    logic              w_clr_we;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clear_busy_q, clear_busy_d;

    vga_fetch_sched #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .hcounter   (hcounter),
        .vcounter   (vcounter),
        .sram_rdata (sram_rdata),
        .rd_slot    (w_rd_slot),
        .rd_addr    (w_rd_addr),
        .pixels     (pixels)
    );

    assign w_eligible = !w_rd_slot && ((BLANK_WRITES_ONLY == 0) || (vcounter > C_V_LAST_VIS));
    assign clear_busy = clear_busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_addr_q   <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clear_busy_d = clear_busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d      = ST_CLEAR;
                    clr_addr_d   = '0;
                    clear_busy_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_eligible) begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == C_LAST_ADDR) begin
                        state_d      = ST_IDLE;
                        clear_busy_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display reads always win; the clear engine shadows the client entirely.
    always_comb begin
        w_clr_we   = (state_q == ST_CLEAR) && w_eligible && !reset;
        wr_ready   = w_eligible && (state_q == ST_IDLE) && !reset;
        sram_re    = w_rd_slot;
        sram_we    = w_clr_we || (wr_valid && wr_ready);
        sram_addr  = wr_addr;
        sram_wdata = wr_data;
        if (w_rd_slot) begin
            sram_addr = w_rd_addr;
        end else if (state_q == ST_CLEAR) begin
            sram_addr  = clr_addr_q;
            sram_wdata = 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_fb_arbiter: directed self-checking bench with SRAM model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [10:0] hcounter;
    logic [9:0]  vcounter;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  sram_rdata;

    logic [7:0]  pixels;
    logic        wr_ready;
    logic        clear_busy;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_we;
    logic        sram_re;

    logic        wr_valid1;
    logic        wr_ready1;
    logic [7:0]  pixels1;
    logic        clear_busy1;
    logic [15:0] sram_addr1;
    logic [7:0]  sram_wdata1;
    logic        sram_we1;
    logic        sram_re1;
    logic [7:0]  sram_rdata1;

    vga_fb_arbiter #(.ADDR_W(16), .BLANK_WRITES_ONLY(0)) dut (
        .clk(clk), .reset(reset), .hcounter(hcounter), .vcounter(vcounter),
        .pixels(pixels), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .clear_busy(clear_busy), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
    );

    vga_fb_arbiter #(.ADDR_W(16), .BLANK_WRITES_ONLY(1)) dut_blank (
        .clk(clk), .reset(reset), .hcounter(hcounter), .vcounter(vcounter),
        .pixels(pixels1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .clear_busy(clear_busy1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
        .sram_we(sram_we1), .sram_re(sram_re1), .sram_rdata(sram_rdata1)
    );

    logic [7:0] mem [0:65535];
    logic       do_preload;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'(i);
        end else begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            if (sram_re) sram_rdata <= mem[sram_addr];
        end
    end

    // next-cycle input values applied by go()
    logic        n_reset, n_wr_valid, n_clear_req, n_wr_valid1;
    logic [15:0] n_wr_addr;
    logic [7:0]  n_wr_data;

    int n_pass = 0, n_tot = 0;
    int both_err = 0, ra_err = 0, clr_err = 0, rdy_err = 0, wr_err = 0, z_err = 0;
    int exp_ra = 0, clr_exp = 0, acc = 0, pend = 0;
    bit mon_rd = 0, mon_clr = 0;
    int exp_wr [int];
    int hh, vv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tot++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    task automatic go(input int h, input int v);
        @(posedge clk);
        #1;
        hcounter  = 11'(h);
        vcounter  = 10'(v);
        reset     = n_reset;
        wr_valid  = n_wr_valid;
        wr_addr   = n_wr_addr;
        wr_data   = n_wr_data;
        clear_req = n_clear_req;
        wr_valid1 = n_wr_valid1;
        #3;
        if (sram_re && sram_we) both_err++;
        if (mon_rd && sram_re) begin
            if (sram_addr !== 16'(exp_ra)) ra_err++;
            exp_ra++;
        end
        if (mon_clr && sram_we) begin
            if (sram_addr !== 16'(clr_exp) || sram_wdata !== 8'h00) clr_err++;
            clr_exp++;
        end
        if (mon_clr && clear_busy && wr_ready) rdy_err++;
    endtask

    initial begin
        reset = 1'b1; hcounter = '0; vcounter = '0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; clear_req = 1'b0; wr_valid1 = 1'b0; sram_rdata1 = 8'h00;
        n_reset = 1'b1; n_wr_valid = 1'b0; n_clear_req = 1'b0; n_wr_valid1 = 1'b0;
        n_wr_addr = '0; n_wr_data = '0;
        do_preload = 1'b1;

        // reset state
        go(1, 300);
        do_preload = 1'b0;
        go(2, 300);
        go(3, 300);
        chk("rst_pixels", pixels, 8'h00);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_sram_we", sram_we, 1'b0);
        chk("rst_clear_busy", clear_busy, 1'b0);
        n_reset = 1'b0;
        go(1, 300);
        chk("idle_wr_ready", wr_ready, 1'b1);

        // one frame of display reads: real timing for lines 0-1, slot cycles only afterwards
        exp_ra = 0; ra_err = 0; mon_rd = 1;
        for (int h = 792; h < 800; h++) go(h, 524);
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 800; h++) begin
                go(h, v);
                if (v == 0 && h == 0)   chk("pix_l0_g0", pixels, 8'd0);
                if (v == 0 && h == 8)   chk("pix_l0_g1", pixels, 8'd1);
                if (v == 0 && h == 600) chk("pix_l0_g75", pixels, 8'd75);
                if (v == 1 && h == 16)  chk("pix_l1_h16", pixels, 8'd82);
                if (v == 1 && h == 23)  chk("pix_l1_h23", pixels, 8'd82);
            end
        end
        for (int v = 2; v < 480; v++) begin
            for (int h = 0; h <= 624; h += 8) go(h, v);
            if (v < 479) go(792, v);
        end
        mon_rd = 0;
        chk("reads_per_frame", 32'(exp_ra), 32'd38400);
        chk("read_addr_seq", 32'(ra_err), 32'd0);
        go(792, 524);
        chk("frame_start_re", sram_re, 1'b1);
        chk("frame_start_addr", sram_addr, 16'd0);

        // client write colliding with a read slot
        n_wr_valid = 1'b1; n_wr_addr = 16'd100; n_wr_data = 8'hA5;
        go(8, 5);
        chk("wr_stall_ready", wr_ready, 1'b0);
        chk("wr_stall_re", sram_re, 1'b1);
        go(9, 5);
        chk("wr_done_ready", wr_ready, 1'b1);
        chk("wr_done_we", sram_we, 1'b1);
        chk("wr_done_addr", sram_addr, 16'd100);
        n_wr_valid = 1'b0;
        go(10, 5);
        chk("wr_mem100", mem[100], 8'hA5);

        // blank-only write instance
        n_wr_valid1 = 1'b1; n_wr_addr = 16'd200; n_wr_data = 8'h3C;
        go(101, 200);
        chk("blank_v200_ready", wr_ready1, 1'b0);
        go(799, 479);
        chk("blank_v479_ready", wr_ready1, 1'b0);
        go(0, 480);
        chk("blank_v480_ready", wr_ready1, 1'b1);
        chk("blank_v480_we", sram_we1, 1'b1);
        chk("blank_v480_addr", sram_addr1, 16'd200);
        chk("blank_v480_data", sram_wdata1, 8'h3C);
        n_wr_valid1 = 1'b0;
        go(1, 480);

        // reset in the middle of line 200
        for (int h = 100; h < 104; h++) go(h, 200);
        n_reset = 1'b1; n_wr_valid = 1'b1; n_wr_addr = 16'd7; n_wr_data = 8'hEE;
        go(105, 200);
        chk("midrst_ready0", wr_ready, 1'b0);
        chk("midrst_we0", sram_we, 1'b0);
        go(106, 200);
        chk("midrst_pixels1", pixels, 8'h00);
        chk("midrst_ready1", wr_ready, 1'b0);
        go(107, 200);
        chk("midrst_pixels2", pixels, 8'h00);
        chk("midrst_we2", sram_we, 1'b0);
        n_reset = 1'b0; n_wr_valid = 1'b0;
        for (int h = 108; h < 136; h++) go(h, 200);
        chk("pixels_unsynced", pixels, 8'h00);
        for (int h = 792; h < 800; h++) go(h, 524);
        for (int h = 0; h < 17; h++) begin
            go(h, 0);
            if (h == 8)  chk("resync_g1", pixels, 8'd1);
            if (h == 16) chk("resync_g2", pixels, 8'd2);
        end

        // random client traffic across two lines
        both_err = 0;
        for (int v = 10; v < 12; v++) begin
            for (int h = 0; h < 800; h++) begin
                if (pend == 0 && $urandom_range(0, 1) == 1) begin
                    n_wr_valid = 1'b1;
                    n_wr_addr  = 16'($urandom_range(0, 38399));
                    n_wr_data  = 8'($urandom);
                    pend = 1;
                end
                go(h, v);
                if (wr_valid && wr_ready) begin
                    exp_wr[int'(wr_addr)] = int'(wr_data);
                    acc++;
                    pend = 0;
                    n_wr_valid = 1'b0;
                end
            end
        end
        n_wr_valid = 1'b0;
        go(0, 12);
        foreach (exp_wr[a]) if (mem[a] !== 8'(exp_wr[a])) wr_err++;
        chk("rand_some_accepted", 32'(acc > 0), 32'd1);
        chk("rand_writes_landed", 32'(wr_err), 32'd0);
        chk("rand_re_we_excl", 32'(both_err), 32'd0);

        // clear-screen engine
        n_clear_req = 1'b1;
        go(0, 480);
        chk("clr_busy_before", clear_busy, 1'b0);
        n_clear_req = 1'b0;
        clr_exp = 0; mon_clr = 1;
        go(1, 480);
        chk("clr_busy_rise", clear_busy, 1'b1);
        chk("clr_wr_ready", wr_ready, 1'b0);
        hh = 1; vv = 480;
        for (int k = 0; k < 45000 && clr_exp < 38400; k++) begin
            n_clear_req = (k == 1000) ? 1'b1 : 1'b0;
            hh++;
            if (hh == 800) begin
                hh = 0; vv++;
                if (vv == 525) vv = 0;
            end
            go(hh, vv);
        end
        n_clear_req = 1'b0;
        chk("clr_count", 32'(clr_exp), 32'd38400);
        chk("clr_busy_last", clear_busy, 1'b1);
        go(hh + 1, vv);
        chk("clr_busy_fall", clear_busy, 1'b0);
        mon_clr = 0;
        for (int i = 0; i < 38400; i++) if (mem[i] !== 8'h00) z_err++;
        chk("clr_zero_fill", 32'(z_err), 32'd0);
        chk("clr_addr_seq", 32'(clr_err), 32'd0);
        chk("clr_ready_blocked", 32'(rdy_err), 32'd0);
        chk("clr_re_we_excl", 32'(both_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
